// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Takes a program image as a byte stream (valid/ready), packs each group of
//   four bytes MSB first into a 32-bit instruction word, and writes the words
//   to consecutive instruction memory locations starting at word 0. The CPU
//   is held in reset while the image loads and for RST_HOLD cycles after the
//   final write, and is then released. An image that stops part-way through a
//   word, or that is longer than MAX_WORDS words, sets a sticky error flag.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   in_valid_i       stream byte valid
//   in_data_i        stream byte
//   in_last_i        marks the final byte of the image (qualified by in_valid_i)
//   in_ready_o       loader accepts a byte this cycle
//   im_we_o          instruction memory write strobe, one cycle per word
//   im_addr_o        instruction memory word index
//   im_wdata_o       assembled instruction word
//   cpu_rst_o        CPU reset, high until the image is loaded and held
//   load_done_o      high once the CPU is released, sticky until reset
//   word_count_o     number of words written so far (saturates at MAX_WORDS)
//   err_partial_o    sticky: image ended part-way through a word
//   err_overflow_o   sticky: byte offered after MAX_WORDS words were written
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned RST_HOLD   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic                  im_we_o,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  output logic [31:0]           im_wdata_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic                  err_partial_o,
  output logic                  err_overflow_o
);

  localparam int unsigned HoldW = $clog2(RST_HOLD) + 1;
  localparam logic [ADDR_WIDTH:0] MaxCount = (ADDR_WIDTH+1)'(MAX_WORDS);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  typedef enum logic [1:0] {StLoad, StHold, StRun, StErr} state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_partial_q, err_partial_d;
  logic                  err_overflow_q, err_overflow_d;
  logic [HoldW-1:0]      hold_q, hold_d;

  logic        accept;
  logic [31:0] placed;
  logic [31:0] word_asm;

  assign accept = in_valid_i && (state_q == StLoad);
  // Byte lands in the lane selected by byte_idx; lanes not yet filled stay
  // zero, which is what pads a short final word.
  assign placed   = {in_data_i, 24'h000000} >> {byte_idx_q, 3'b000};
  assign word_asm = shift_q | placed;

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    shift_d        = shift_q;
    we_d           = 1'b0;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    count_d        = count_q;
    err_partial_d  = err_partial_q;
    err_overflow_d = err_overflow_q;
    hold_d         = hold_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (count_q == MaxCount) begin
            // Memory is full: drop the byte and never release the CPU.
            err_overflow_d = 1'b1;
            state_d        = StErr;
          end else if (byte_idx_q == 2'd3 || in_last_i) begin
            we_d       = 1'b1;
            addr_d     = count_q[ADDR_WIDTH-1:0];
            wdata_d    = word_asm;
            count_d    = count_q + (ADDR_WIDTH+1)'(1);
            shift_d    = '0;
            byte_idx_d = 2'd0;
            if (in_last_i) begin
              state_d = StHold;
              hold_d  = '0;
              if (byte_idx_q != 2'd3) err_partial_d = 1'b1;
            end
          end else begin
            shift_d    = word_asm;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      StHold: begin
        if (hold_q == HoldLast) state_d = StRun;
        else                    hold_d  = hold_q + HoldW'(1);
      end
      StRun:  ;
      StErr:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StLoad;
      byte_idx_q     <= 2'd0;
      shift_q        <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      count_q        <= '0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      count_q        <= count_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
      hold_q         <= hold_d;
    end
  end

  assign in_ready_o     = (state_q == StLoad);
  assign im_we_o        = we_q;
  assign im_addr_o      = addr_q;
  assign im_wdata_o     = wdata_q;
  assign cpu_rst_o      = (state_q != StRun);
  assign load_done_o    = (state_q == StRun);
  assign word_count_o   = count_q;
  assign err_partial_o  = err_partial_q;
  assign err_overflow_o = err_overflow_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader. Two instances share one input stream: a default
// sized loader and a two-word loader that exercises the overflow path.
module tb_imem_boot_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned MW  = 1024;
  localparam int unsigned RH  = 4;
  localparam int unsigned SAW = 1;
  localparam int unsigned SMW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_last = 1'b0;

  logic          a_ready, a_we, a_cpu_rst, a_done, a_errp, a_erro;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [AW:0]   a_wc;

  logic           b_ready, b_we, b_cpu_rst, b_done, b_errp, b_erro;
  logic [SAW-1:0] b_addr;
  logic [31:0]    b_wdata;
  logic [SAW:0]   b_wc;

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW), .RST_HOLD(RH)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(a_ready), .im_we_o(a_we), .im_addr_o(a_addr),
    .im_wdata_o(a_wdata), .cpu_rst_o(a_cpu_rst), .load_done_o(a_done),
    .word_count_o(a_wc), .err_partial_o(a_errp), .err_overflow_o(a_erro)
  );

  imem_boot_loader #(.ADDR_WIDTH(SAW), .MAX_WORDS(SMW), .RST_HOLD(RH)) dut_small (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(b_ready), .im_we_o(b_we), .im_addr_o(b_addr),
    .im_wdata_o(b_wdata), .cpu_rst_o(b_cpu_rst), .load_done_o(b_done),
    .word_count_o(b_wc), .err_partial_o(b_errp), .err_overflow_o(b_erro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int we_cyc = -1;
  int fall_cyc = -1;

  logic [7:0]  stim[$];
  logic [31:0] a_wd[$];
  int          a_wa[$];
  logic [31:0] b_wd[$];
  int          b_wa[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobed cycle is one captured write.
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      a_wd.push_back(a_wdata);
      a_wa.push_back(int'(a_addr));
      we_cyc = cyc;
    end
    if (b_we === 1'b1) begin
      b_wd.push_back(b_wdata);
      b_wa.push_back(int'(b_addr));
    end
    if (a_cpu_rst === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_wd.delete(); a_wa.delete(); b_wd.delete(); b_wa.delete();
    we_cyc = -1; fall_cyc = -1; acc_cyc = -1;
  endtask

  // gap_mode: 0 back-to-back, 1 one valid cycle in three, 2 random 0..2 idle.
  task automatic drive_stream(input int gap_mode, input bit with_last);
    int g;
    for (int i = 0; i < stim.size(); i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = with_last && (i == stim.size() - 1);
      @(posedge clk);
      #1;
      if (in_last) acc_cyc = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(2, 0));
      repeat (g) begin @(posedge clk); #1; end
    end
    if (with_last) begin
      // Bytes offered after the image must all be ignored.
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (RH + 4) @(posedge clk);
      #1;
    end
  endtask

  // Reference: image split into 4-byte MSB-first words, short tail zero
  // padded; an image longer than the capacity keeps only the first words.
  task automatic compare_model(input string name);
    int n, maxw, nw, got_n, got_wc, idx, exp_a, got_a;
    bit ovf, part, run;
    logic [31:0] exp_w, got_w;
    logic gp, go, gr, gd, grdy;
    n = stim.size();
    for (int k = 0; k < 2; k++) begin
      maxw = (k == 0) ? int'(MW) : int'(SMW);
      ovf  = n > maxw * 4;
      nw   = ovf ? maxw : (n + 3) / 4;
      part = !ovf && (n % 4 != 0);
      run  = !ovf;
      got_n = (k == 0) ? a_wd.size() : b_wd.size();
      checks++;
      if (got_n != nw) begin
        errors++;
        $display("FAIL %s[%0d] write_count: got %0d expected %0d", name, k, got_n, nw);
      end
      for (int j = 0; j < nw && j < got_n; j++) begin
        exp_w = 32'h0;
        for (int b = 0; b < 4; b++) begin
          idx = 4 * j + b;
          exp_w = exp_w * 256 + ((idx < n) ? 32'(stim[idx]) : 32'h0);
        end
        exp_a = j;
        got_w = (k == 0) ? a_wd[j] : b_wd[j];
        got_a = (k == 0) ? a_wa[j] : b_wa[j];
        checks++;
        if (got_w !== exp_w || got_a != exp_a) begin
          errors++;
          $display("FAIL %s[%0d] write%0d: got %08h@%0d expected %08h@%0d",
                   name, k, j, got_w, got_a, exp_w, exp_a);
        end
      end
      got_wc = (k == 0) ? int'(a_wc) : int'(b_wc);
      gp   = (k == 0) ? a_errp : b_errp;
      go   = (k == 0) ? a_erro : b_erro;
      gr   = (k == 0) ? a_cpu_rst : b_cpu_rst;
      gd   = (k == 0) ? a_done : b_done;
      grdy = (k == 0) ? a_ready : b_ready;
      checks++;
      if (got_wc != nw) begin
        errors++;
        $display("FAIL %s[%0d] word_count: got %0d expected %0d", name, k, got_wc, nw);
      end
      checks++;
      if (gp !== part || go !== ovf) begin
        errors++;
        $display("FAIL %s[%0d] err_flags: got p=%b o=%b expected p=%b o=%b",
                 name, k, gp, go, part, ovf);
      end
      checks++;
      if (gr !== !run || gd !== run || grdy !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] cpu_state: got rst=%b done=%b rdy=%b expected %b %b 0",
                 name, k, gr, gd, grdy, !run, run);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hff;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_we !== 1'b0 || a_addr !== '0 || a_wdata !== 32'h0 || a_wc !== '0) begin
      errors++;
      $display("FAIL reset_write: got we=%b addr=%0d data=%h wc=%0d expected 0 0 0 0",
               a_we, a_addr, a_wdata, a_wc);
    end
    checks++;
    if (a_cpu_rst !== 1'b1 || a_done !== 1'b0 || a_errp !== 1'b0 || a_erro !== 1'b0
        || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got rst=%b done=%b ep=%b eo=%b rdy=%b expected 1 0 0 0 1",
               a_cpu_rst, a_done, a_errp, a_erro, a_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8c, 8'h09, 8'h00, 8'h50};
    drive_stream(0, 1'b1);
    compare_model("basic");
    checks++;
    if (we_cyc != acc_cyc) begin
      errors++;
      $display("FAIL basic latency: got write cycle %0d expected %0d", we_cyc, acc_cyc);
    end
    checks++;
    if (fall_cyc - we_cyc != int'(RH)) begin
      errors++;
      $display("FAIL basic cpu_rst_release: got %0d cycles expected %0d",
               fall_cyc - we_cyc, RH);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8c, 8'h09, 8'h00, 8'h50};
    drive_stream(1, 1'b1);
    compare_model("gapped");
  endtask

  task automatic test_partial();
    do_reset();
    stim = '{8'h12, 8'h34};
    drive_stream(0, 1'b1);
    compare_model("partial");
  endtask

  task automatic test_overflow();
    do_reset();
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(8'($urandom));
    drive_stream(0, 1'b1);
    compare_model("overflow");
  endtask

  task automatic test_reset_midload();
    do_reset();
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    drive_stream(0, 1'b0);
    do_reset();
    stim = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    drive_stream(0, 1'b1);
    compare_model("midload_reset");
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 12; t++) begin
      do_reset();
      stim.delete();
      len = int'($urandom_range(40, 1));
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
      drive_stream(2, 1'b1);
      compare_model($sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_partial();
    test_overflow();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
